fp_accumulator: RTL and testbench

Streaming single-precision accumulator that reduces a group of IEEE-754 words to one sum by driving the shared floating-point adder as its initiator. It presents operands on the adder's `input_a`/`input_b`/`input_stb` side and consumes results on its `output_z`/`output_z_stb`/`output_z_ack` side. It sits between the block-multiplier product stream and the result writer, summing partial products into one output element.

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_accum_watchdog.sv | 29 ++
 rtl/fp_accumulator.sv | 185 ++++++++++++++++++
 tb/tb_fp_accumulator.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point accumulator: FSM state encoding
// and the IEEE-754 single-precision constants it loads without computing.
package fp_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_ACK,
    ST_OUT
  } fp_acc_state_t;

  localparam logic [DATA_W-1:0] FP_QNAN = 32'h7FC0_0000;
  localparam logic [DATA_W-1:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_accum_watchdog.sv
// Adder response watchdog: counts cycles spent waiting on the adder and flags
// expiry on the LIMIT-th waiting cycle. Used only with FP_ACCUM_TIMEOUT_EN.
module fp_accum_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= '0;
    end else if (run && (r_cnt != W'(LIMIT))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign expired = run && (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/fp_accumulator.sv
// Streaming single-precision accumulator that drives a shared FP adder as
// initiator. Optional adder watchdog enabled by defining FP_ACCUM_TIMEOUT_EN.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_stb,
  input  logic [DATA_W-1:0] add_z,
  input  logic              add_z_stb,
  output logic              add_z_ack,
  output logic [DATA_W-1:0] sum_data,
  output logic [CNT_W-1:0]  sum_count,
  output logic              sum_err,
  output logic              sum_valid,
  input  logic              sum_ready
);

  fp_acc_state_t     r_state;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_opb;
  logic [CNT_W-1:0]  r_count;
  logic              r_last;
  logic              r_in_ready;
  logic              r_add_stb;
  logic              r_add_z_ack;
  logic              r_sum_valid;
  logic              w_accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept = r_in_ready & in_valid;

`ifdef FP_ACCUM_TIMEOUT_EN
  logic r_drop;
  logic r_sum_err;
  logic w_wd_start;
  logic w_wd_run;
  logic w_expired;

  // The counter is cleared by the same accept that launches a pair into ISSUE.
  assign w_wd_start = (r_state == ST_WAIT) && w_accept && !r_drop;
  assign w_wd_run   = (r_state == ST_ISSUE);

  fp_accum_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (w_wd_start),
    .run    (w_wd_run),
    .expired(w_expired)
  );

  assign sum_err = r_sum_err;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign sum_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= FP_ZERO;
      r_opb       <= FP_ZERO;
      r_count     <= '0;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_add_stb   <= 1'b0;
      r_add_z_ack <= 1'b0;
      r_sum_valid <= 1'b0;
`ifdef FP_ACCUM_TIMEOUT_EN
      r_drop      <= 1'b0;
      r_sum_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_acc   <= in_data;
            r_count <= CNT_W'(1);
            if (in_last) begin
              r_in_ready  <= 1'b0;
              r_sum_valid <= 1'b1;
              r_state     <= ST_OUT;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_accept) begin
            r_count <= sat_inc(r_count);
`ifdef FP_ACCUM_TIMEOUT_EN
            // After a timeout the rest of the group is swallowed unissued.
            if (r_drop) begin
              if (in_last) begin
                r_drop      <= 1'b0;
                r_in_ready  <= 1'b0;
                r_sum_valid <= 1'b1;
                r_state     <= ST_OUT;
              end
            end else
`endif
            begin
              r_opb      <= in_data;
              r_last     <= in_last;
              r_in_ready <= 1'b0;
              r_add_stb  <= 1'b1;
              r_state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          // Strobe drops together with the ack so the adder cannot re-capture.
          if (add_z_stb) begin
            r_add_stb   <= 1'b0;
            r_add_z_ack <= 1'b1;
            r_state     <= ST_ACK;
          end
`ifdef FP_ACCUM_TIMEOUT_EN
          else if (w_expired) begin
            r_add_stb <= 1'b0;
            r_acc     <= FP_QNAN;
            r_sum_err <= 1'b1;
            if (r_last) begin
              r_sum_valid <= 1'b1;
              r_state     <= ST_OUT;
            end else begin
              r_drop     <= 1'b1;
              r_in_ready <= 1'b1;
              r_state    <= ST_WAIT;
            end
          end
`endif
        end
        ST_ACK: begin
          r_add_z_ack <= 1'b0;
          r_acc       <= add_z;
          if (r_last) begin
            r_sum_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= ST_WAIT;
          end
        end
        ST_OUT: begin
          if (sum_ready) begin
            r_sum_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
`ifdef FP_ACCUM_TIMEOUT_EN
            r_sum_err   <= 1'b0;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign add_a     = r_acc;
  assign add_b     = r_opb;
  assign add_stb   = r_add_stb;
  assign add_z_ack = r_add_z_ack;
  assign sum_data  = r_acc;
  assign sum_count = r_count;
  assign sum_valid = r_sum_valid;

endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator with a behavioural FP adder model;
// the watchdog sequence is compiled in when FP_ACCUM_TIMEOUT_EN is defined.
module tb_fp_accumulator;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_stb;
  logic [31:0] add_z;
  logic        add_z_stb;
  logic        add_z_ack;
  logic [31:0] sum_data;
  logic [15:0] sum_count;
  logic        sum_err;
  logic        sum_valid;
  logic        sum_ready;

  int n_tests = 0;
  int n_fail  = 0;

  fp_accumulator #(
    .TIMEOUT_CYCLES(64),
    .CNT_W         (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_stb  (add_stb),
    .add_z    (add_z),
    .add_z_stb(add_z_stb),
    .add_z_ack(add_z_ack),
    .sum_data (sum_data),
    .sum_count(sum_count),
    .sum_err  (sum_err),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- single-precision <-> real helpers (normals and zero)
  function automatic real sp2real(input logic [31:0] s);
    if (s[30:23] == 8'd0) return 0.0;
    return $bitstoreal({s[31], 11'(int'(s[30:23]) - 127 + 1023), s[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] b;
    b = $realtobits(r);
    if (b[62:52] == 11'd0) return {b[63], 31'd0};
    return {b[63], 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
  endfunction

  // ---------------- behavioural adder (input_stb / output_z_stb / output_z_ack)
  int          ad_state = 0;
  int          ad_lat   = 0;
  int          n_comp   = 0;
  logic [31:0] ad_z     = 32'd0;
  logic        ad_z_stb = 1'b0;
  logic        stub_dead = 1'b0;

  assign add_z     = ad_z;
  assign add_z_stb = ad_z_stb;

  always @(posedge clk) begin
    if (!rst) begin
      ad_state <= 0;
      ad_z_stb <= 1'b0;
    end else begin
      case (ad_state)
        0: if (add_stb) begin
          ad_z     <= real2sp(sp2real(add_a) + sp2real(add_b));
          ad_lat   <= int'($urandom_range(4, 1));
          n_comp   <= n_comp + 1;
          ad_state <= 1;
        end
        1: if (ad_lat <= 1) begin
          if (!stub_dead) begin
            ad_z_stb <= 1'b1;
            ad_state <= 2;
          end
        end else begin
          ad_lat <= ad_lat - 1;
        end
        default: if (add_z_ack) begin
          ad_z_stb <= 1'b0;
          ad_state <= 0;
        end
      endcase
    end
  end

  // ---------------- handshake monitor, sampled on the falling edge
  int          n_ack = 0;
  int          n_stb = 0;
  int          viol  = 0;
  logic        prev_ack = 1'b0;
  logic        prev_stb = 1'b0;
  logic [31:0] prev_a = 32'd0;
  logic [31:0] prev_b = 32'd0;

  always @(negedge clk) begin
    if (add_z_ack) n_ack <= n_ack + 1;
    if (add_stb) n_stb <= n_stb + 1;
    if ((add_z_ack && add_stb) || (add_z_ack && prev_ack) ||
        (add_stb && prev_stb && ((add_a !== prev_a) || (add_b !== prev_b))))
      viol <= viol + 1;
    prev_ack <= add_z_ack;
    prev_stb <= add_stb;
    prev_a   <= add_a;
    prev_b   <= add_b;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish within time limit");
    $fatal(1);
  end

  // ---------------- checking and driving tasks
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_elem(input logic [31:0] d, input logic last, input logic first,
                           input logic check);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = $urandom;
    if (check && !first) chk("stb_after_accept", {31'd0, add_stb}, 32'd1);
    if (check && first && last) chk("single_out_next", {31'd0, sum_valid}, 32'd1);
  endtask

  logic [31:0] gq[$];

  task automatic send_group(input int gap_max);
    for (int i = 0; i < gq.size(); i++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      send_elem(gq[i], i == gq.size() - 1, i == 0, 1'b1);
    end
  endtask

  task automatic get_sum(input string nm, input logic [31:0] es, input int ec,
                         input int ecomp, input int eack, input logic eerr,
                         input int hold, input int comp0, input int ack0);
    int t;
    logic [31:0] d0;
    logic stable;
    t = 0;
    while (!sum_valid && t < 500) begin
      tick();
      t++;
    end
    chk({nm, "_valid"}, {31'd0, sum_valid}, 32'd1);
    if (hold > 0) begin
      d0 = sum_data;
      stable = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      in_last  = 1'b1;
      repeat (hold) begin
        tick();
        if (!sum_valid || sum_data !== d0 || in_ready) stable = 1'b0;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk({nm, "_hold_stable"}, {31'd0, stable}, 32'd1);
    end
    chk({nm, "_data"}, sum_data, es);
    chk({nm, "_count"}, {16'd0, sum_count}, ec);
    chk({nm, "_err"}, {31'd0, sum_err}, {31'd0, eerr});
    chk({nm, "_adds"}, n_comp - comp0, ecomp);
    chk({nm, "_acks"}, n_ack - ack0, eack);
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    chk({nm, "_released"}, {31'd0, sum_valid}, 32'd0);
  endtask

  typedef struct {
    int               n;
    logic [3:0][31:0] d;
    logic [31:0]      exp_sum;
    int               exp_cnt;
    int               hold;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          c0, a0, s0, n, acc;
    logic [31:0] e;

    vecs[0] = '{3, {32'h0, 32'h40400000, 32'h40000000, 32'h3F800000}, 32'h40C00000, 3, 0};
    vecs[1] = '{1, {32'h0, 32'h0, 32'h0, 32'hC0A00000}, 32'hC0A00000, 1, 0};
    vecs[2] = '{2, {32'h0, 32'h0, 32'hBF800000, 32'h3F800000}, 32'h00000000, 2, 10};
    vecs[3] = '{4, {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}, 32'h41200000, 4, 2};
    vecs[4] = '{2, {32'h0, 32'h0, 32'hC0800000, 32'h40000000}, 32'hC0000000, 2, 0};

    rst = 1'b0;
    in_data = 32'd0;
    in_valid = 1'b0;
    in_last = 1'b0;
    sum_ready = 1'b0;
    repeat (3) tick();

    // reset values
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_add_stb", {31'd0, add_stb}, 32'd0);
    chk("rst_add_z_ack", {31'd0, add_z_ack}, 32'd0);
    chk("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
    chk("rst_sum_err", {31'd0, sum_err}, 32'd0);
    chk("rst_sum_data", sum_data, 32'd0);
    chk("rst_sum_count", {16'd0, sum_count}, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    rst = 1'b1;
    tick();
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // directed vectors
    for (int v = 0; v < 5; v++) begin
      gq.delete();
      for (int i = 0; i < vecs[v].n; i++) gq.push_back(vecs[v].d[i]);
      c0 = n_comp;
      a0 = n_ack;
      s0 = n_stb;
      send_group(0);
      get_sum($sformatf("vec%0d", v), vecs[v].exp_sum, vecs[v].exp_cnt,
              vecs[v].n - 1, vecs[v].n - 1, 1'b0, vecs[v].hold, c0, a0);
      if (vecs[v].n == 1) chk("single_no_stb", n_stb - s0, 32'd0);
    end

    // reset during ISSUE, then a fresh group
    send_elem(32'h40A00000, 1'b0, 1'b1, 1'b1);
    send_elem(32'h40E00000, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    chk("midrst_add_stb", {31'd0, add_stb}, 32'd0);
    chk("midrst_sum_valid", {31'd0, sum_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_add_a", add_a, 32'd0);
    rst = 1'b1;
    tick();
    gq.delete();
    gq.push_back(32'h40A00000);
    gq.push_back(32'h40E00000);
    c0 = n_comp;
    a0 = n_ack;
    send_group(0);
    get_sum("after_rst", 32'h41400000, 2, 1, 1, 1'b0, 0, c0, a0);

    // randomized groups against an integer-sum reference
    for (int g = 0; g < 30; g++) begin
      n = int'($urandom_range(6, 1));
      acc = 0;
      gq.delete();
      for (int i = 0; i < n; i++) begin
        int x;
        x = int'($urandom_range(200, 0)) - 100;
        acc += x;
        gq.push_back(real2sp($itor(x)));
      end
      e = real2sp($itor(acc));
      c0 = n_comp;
      a0 = n_ack;
      send_group(3);
      get_sum($sformatf("rand%0d", g), e, n, n - 1, n - 1, 1'b0,
              int'($urandom_range(3, 0)), c0, a0);
    end

`ifdef FP_ACCUM_TIMEOUT_EN
    // adder never answers: watchdog fires, rest of group is swallowed
    stub_dead = 1'b1;
    c0 = n_comp;
    a0 = n_ack;
    s0 = n_stb;
    send_elem(32'h3F800000, 1'b0, 1'b1, 1'b1);
    send_elem(32'h40000000, 1'b0, 1'b0, 1'b1);
    send_elem(32'h40400000, 1'b1, 1'b0, 1'b0);
    get_sum("timeout", 32'h7FC00000, 3, 1, 0, 1'b1, 0, c0, a0);
    chk("timeout_issue_cycles", n_stb - s0, 32'd64);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    stub_dead = 1'b0;
    tick();
`endif

    chk("handshake_violations", viol, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
